// File: rtl/serial_tx_scheduler_pkg.sv
// Shared definitions for the serial transmit scheduler: FSM encoding and width helpers.
package serial_tx_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_ID    = 3'd2,
    ST_DATA  = 3'd3,
    ST_STOP  = 3'd4
  } state_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    int unsigned span;
    r    = 0;
    span = 1;
    while (span < value) begin
      span = span * 2;
      r    = r + 1;
    end
    return r;
  endfunction

  function automatic int unsigned max1_clog2(input int unsigned value);
    return (clog2(value) < 1) ? 1 : clog2(value);
  endfunction

endpackage

// File: rtl/serial_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above pointer, wrapping.
module rr_arbiter
  import serial_tx_scheduler_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = max1_clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic               enable,
  input  logic [IDX_W-1:0]   pointer,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_grant
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = '0;
    if (enable) begin
      for (int unsigned off = 0; off < NUM_REQ; off++) begin
        idx = IDX_W'((32'(pointer) + off) % NUM_REQ);
        if (!any_grant && req[idx]) begin
          grant[idx] = 1'b1;
          grant_idx  = idx;
          any_grant  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/serial_tx_scheduler.sv
// Shares one serial lane among NUM_REQ word sources: frame = start, source ID, data LSB-first, stop.
module serial_tx_scheduler
  import serial_tx_scheduler_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int NUM_REQ    = 4,
  parameter  int BIT_CYCLES = 1,
  localparam int ID_WIDTH   = max1_clog2(NUM_REQ)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          serial_out,
  output logic                          busy,
  output logic [ID_WIDTH-1:0]           grant_id,
  output logic                          frame_done
);

  localparam int CYC_W = max1_clog2(BIT_CYCLES);
  localparam int BIT_W = max1_clog2(DATA_WIDTH + ID_WIDTH + 1);

  state_t                  state;
  logic [ID_WIDTH-1:0]     pointer;
  logic [ID_WIDTH-1:0]     id_sh;
  logic [ID_WIDTH-1:0]     arb_idx;
  logic [DATA_WIDTH-1:0]   shreg;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic [CYC_W-1:0]        cyc_cnt;
  logic [BIT_W-1:0]        bit_cnt;
  logic [NUM_REQ-1:0]      arb_grant;
  logic                    arb_en;
  logic                    any_grant;
  logic                    bit_end;

  // Gating with reset keeps req_ready low while reset is held.
  assign arb_en    = enable && (state == ST_IDLE) && !reset;
  assign req_ready = arb_grant;
  assign bit_end   = (cyc_cnt == CYC_W'(BIT_CYCLES - 1));

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req       (req_valid),
    .enable    (arb_en),
    .pointer   (pointer),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_grant (any_grant)
  );

  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == ID_WIDTH'(i)) sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // serial_out always carries the current bit; shift registers are pre-shifted as each bit is issued.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      pointer    <= '0;
      id_sh      <= '0;
      shreg      <= '0;
      cyc_cnt    <= '0;
      bit_cnt    <= '0;
      serial_out <= 1'b0;
      busy       <= 1'b0;
      grant_id   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (state == ST_IDLE) begin
        if (any_grant) begin
          shreg      <= sel_data;
          grant_id   <= arb_idx;
          id_sh      <= arb_idx;
          pointer    <= (arb_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
          state      <= ST_START;
          serial_out <= 1'b1;
          busy       <= 1'b1;
          cyc_cnt    <= '0;
          bit_cnt    <= '0;
        end
      end else if (!bit_end) begin
        cyc_cnt <= cyc_cnt + 1'b1;
      end else begin
        cyc_cnt <= '0;
        case (state)
          ST_START: begin
            state      <= ST_ID;
            serial_out <= id_sh[0];
            id_sh      <= id_sh >> 1;
            bit_cnt    <= '0;
          end
          ST_ID: begin
            if (bit_cnt == BIT_W'(ID_WIDTH - 1)) begin
              state      <= ST_DATA;
              serial_out <= shreg[0];
              shreg      <= shreg >> 1;
              bit_cnt    <= '0;
            end else begin
              serial_out <= id_sh[0];
              id_sh      <= id_sh >> 1;
              bit_cnt    <= bit_cnt + 1'b1;
            end
          end
          ST_DATA: begin
            if (bit_cnt == BIT_W'(DATA_WIDTH - 1)) begin
              state      <= ST_STOP;
              serial_out <= 1'b0;
            end else begin
              serial_out <= shreg[0];
              shreg      <= shreg >> 1;
              bit_cnt    <= bit_cnt + 1'b1;
            end
          end
          ST_STOP: begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
            serial_out <= 1'b0;
          end
          default: begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            serial_out <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_tx_scheduler.sv
// Directed bench for serial_tx_scheduler: default instance plus a BIT_CYCLES=3 instance.
module tb_serial_tx_scheduler;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable, enable3;
  logic [3:0]  req_valid, req_valid3;
  logic [31:0] req_data, req_data3;
  logic [3:0]  req_ready, req_ready3;
  logic        serial_out, serial_out3;
  logic        busy, busy3;
  logic [1:0]  grant_id, grant_id3;
  logic        frame_done, frame_done3;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [3:0] valid;
    logic [3:0] exp_ready;
    logic       exp_ser;
    logic       exp_busy;
    logic       exp_done;
    logic [1:0] exp_gid;
  } vec_t;

  vec_t        tbl [15];
  logic [11:0] fb;
  int          waited;
  int          cnt;

  always #5 clock = ~clock;

  serial_tx_scheduler dut (
    .clock(clock), .reset(reset), .enable(enable), .req_valid(req_valid),
    .req_data(req_data), .req_ready(req_ready), .serial_out(serial_out),
    .busy(busy), .grant_id(grant_id), .frame_done(frame_done)
  );

  serial_tx_scheduler #(.DATA_WIDTH(8), .NUM_REQ(4), .BIT_CYCLES(3)) dut3 (
    .clock(clock), .reset(reset), .enable(enable3), .req_valid(req_valid3),
    .req_data(req_data3), .req_ready(req_ready3), .serial_out(serial_out3),
    .busy(busy3), .grant_id(grant_id3), .frame_done(frame_done3)
  );

  function automatic logic [11:0] frame_bits(input logic [1:0] id, input logic [7:0] d);
    return {1'b0, d, id, 1'b1};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next();
    @(negedge clock);
    #1;
  endtask

  task automatic wait_ready(output int w);
    w = 0;
    while (req_ready == 4'b0 && w < 40) begin
      next();
      w++;
    end
    if (w >= 40) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_ready: actual timeout required grant within 40 cycles");
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    tbl = '{
      '{4'b0100, 4'b0100, 1'b0, 1'b0, 1'b0, 2'd0},
      '{4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd2},
      '{4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd2},
      '{4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd2},
      '{4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd2},
      '{4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd2},
      '{4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd2},
      '{4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd2},
      '{4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd2},
      '{4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd2},
      '{4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd2},
      '{4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd2},
      '{4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd2},
      '{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd2},
      '{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd2}
    };

    reset      = 1'b1;
    enable     = 1'b1;
    req_valid  = 4'b1111;
    req_data   = {8'h44, 8'h33, 8'h22, 8'h11};
    enable3    = 1'b1;
    req_valid3 = 4'b0000;
    req_data3  = 32'h0;

    // Reset defaults with every source requesting
    next();
    next();
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_serial", 32'(serial_out), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_gid", 32'(grant_id), 32'h0);
    chk("rst_done", 32'(frame_done), 32'h0);
    reset = 1'b0;
    #1;
    chk("first_grant", 32'(req_ready), 32'h1);

    // Round robin 0,1,2,3,0 at 13-cycle spacing
    for (int n = 0; n < 5; n++) begin
      if (n > 0) begin
        wait_ready(waited);
        chk("rr_spacing", 32'(waited + 1), 32'd13);
      end
      chk("rr_grant", 32'(req_ready), 32'(1 << (n % 4)));
      next();
      chk("rr_gid", 32'(grant_id), 32'(n % 4));
    end
    req_valid = 4'b0000;
    cnt = 0;
    while (!frame_done && cnt < 40) begin
      next();
      cnt++;
    end
    chk("rr_last_done", 32'(frame_done), 32'h1);
    next();

    // Single frame from source 2, data A5 (pointer is now 1)
    req_data = {8'h44, 8'hA5, 8'h22, 8'h11};
    for (int i = 0; i < 15; i++) begin
      req_valid = tbl[i].valid;
      #1;
      chk("tbl_ready", 32'(req_ready), 32'(tbl[i].exp_ready));
      chk("tbl_serial", 32'(serial_out), 32'(tbl[i].exp_ser));
      chk("tbl_busy", 32'(busy), 32'(tbl[i].exp_busy));
      chk("tbl_done", 32'(frame_done), 32'(tbl[i].exp_done));
      chk("tbl_gid", 32'(grant_id), 32'(tbl[i].exp_gid));
      next();
    end

    // Enable gating: pointer must stay at 3
    enable    = 1'b0;
    req_valid = 4'b1000;
    for (int i = 0; i < 20; i++) begin
      #1;
      chk("en_off_ready", 32'(req_ready), 32'h0);
      chk("en_off_busy", 32'(busy), 32'h0);
      next();
    end
    enable    = 1'b1;
    req_valid = 4'b1111;
    #1;
    chk("en_on_grant3", 32'(req_ready), 32'h8);
    next();
    enable = 1'b0;
    cnt = 1;
    while (!frame_done && cnt < 40) begin
      next();
      cnt++;
    end
    chk("en_mid_frame_len", 32'(cnt), 32'd13);
    for (int i = 0; i < 15; i++) begin
      next();
      chk("en_after_ready", 32'(req_ready), 32'h0);
      chk("en_after_busy", 32'(busy), 32'h0);
    end
    req_valid = 4'b0001;
    req_data  = {8'h44, 8'h33, 8'h22, 8'h3C};
    enable    = 1'b1;
    #1;
    chk("en_resume_grant0", 32'(req_ready), 32'h1);

    // Reset during data bit 4, then a fresh frame with pointer back at 0
    next();
    req_valid = 4'b0000;
    repeat (7) next();
    chk("pre_reset_serial", 32'(serial_out), 32'h1);
    reset = 1'b1;
    #1;
    chk("async_rst_serial", 32'(serial_out), 32'h0);
    chk("async_rst_busy", 32'(busy), 32'h0);
    next();
    reset     = 1'b0;
    req_valid = 4'b0011;
    #1;
    chk("post_rst_ptr0", 32'(req_ready), 32'h1);
    next();
    req_valid = 4'b0000;
    fb = frame_bits(2'd0, 8'h3C);
    for (int k = 0; k < 12; k++) begin
      chk("refr_bit", 32'(serial_out), 32'(fb[k]));
      next();
    end
    chk("refr_done", 32'(frame_done), 32'h1);
    chk("refr_gid", 32'(grant_id), 32'h0);

    // Bit stretching on the BIT_CYCLES=3 instance
    req_valid3 = 4'b0010;
    req_data3  = {8'h00, 8'h00, 8'hFF, 8'h00};
    #1;
    chk("bc3_grant", 32'(req_ready3), 32'h2);
    next();
    req_valid3 = 4'b0000;
    fb = frame_bits(2'd1, 8'hFF);
    for (int k = 0; k < 36; k++) begin
      chk("bc3_bit", 32'(serial_out3), 32'(fb[k / 3]));
      if (k == 35) chk("bc3_not_done_early", 32'(frame_done3), 32'h0);
      next();
    end
    chk("bc3_done", 32'(frame_done3), 32'h1);
    chk("bc3_busy", 32'(busy3), 32'h0);
    chk("bc3_gid", 32'(grant_id3), 32'h1);
    next();
    chk("bc3_done_pulse", 32'(frame_done3), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
